// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, plus immediate-format and ALU-control decode.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BR  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  state_e state_q, state_d;
  aluop_e aluop;
  logic   ir_en, pc_update, branch, reg_en, mem_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; undefined encodings fall through to all-zero/FETCH.
  always_comb begin
    state_d   = S_FETCH;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    adrsrc    = 1'b0;
    aluop     = ALUOP_ADD;
    ir_en     = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_en    = 1'b0;
    mem_en    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_en     = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        reg_en    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        mem_en = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_en = 1'b1;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Extender format straight from the opcode.
  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BR:   immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // ALU control; sub only for R-type (op[5]) with funct7b5 set.
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_SUB: alucontrol = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Architectural write enables are held off while reset is asserted.
  assign irwrite  = ir_en & ~reset;
  assign pcwrite  = (pc_update | (branch & (zero ^ funct3[0]))) & ~reset;
  assign regwrite = reg_en & ~reset;
  assign memwrite = mem_en & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model queues per-cycle
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [2:0] alu;
    logic       adr;
    logic       ir;
    logic       pc;
    logic       rw;
    logic       mw;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic [2:0] alucontrol;
  logic       adrsrc, irwrite, pcwrite, regwrite, memwrite;
  logic [3:0] state;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .alucontrol(alucontrol), .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  function automatic obs_t mk(input logic [3:0] st, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] rs, input logic [2:0] alu, input logic adr,
                              input logic ir, input logic pc, input logic rw, input logic mw);
    obs_t o;
    o.st = st; o.imm = 2'b00; o.a = a; o.b = b; o.rs = rs; o.alu = alu;
    o.adr = adr; o.ir = ir; o.pc = pc; o.rw = rw; o.mw = mw;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d imm=%b a=%b b=%b rs=%b alu=%b adr=%b ir=%b pc=%b rw=%b mw=%b",
                     o.st, o.imm, o.a, o.b, o.rs, o.alu, o.adr, o.ir, o.pc, o.rw, o.mw);
  endfunction

  // Immediate format implied by the instruction's encoding type.
  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic operation named by funct3; only register-register ops can subtract.
  function automatic logic [2:0] alu_of(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t rst_rec(input logic [6:0] o);
    obs_t r;
    r = mk(4'd0, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    r.imm = imm_of(o);
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Expected per-cycle trace of one instruction, from the instruction's meaning.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, output obs_t seq[$]);
    logic taken;
    seq = {};
    seq.push_back(mk(4'd0, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    seq.push_back(mk(4'd1, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (o == LW) begin
      seq.push_back(mk(4'd2, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      seq.push_back(mk(4'd3, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      seq.push_back(mk(4'd4, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (o == SW) begin
      seq.push_back(mk(4'd2, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      seq.push_back(mk(4'd5, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end else if (o == RT || o == IT) begin
      seq.push_back(mk((o == RT) ? 4'd6 : 4'd8, 2'b10, (o == RT) ? 2'b00 : 2'b01, 2'b00,
                       alu_of(o == RT, f3, f7), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      seq.push_back(mk(4'd7, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (o == JL) begin
      seq.push_back(mk(4'd9, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      seq.push_back(mk(4'd7, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (o == BR) begin
      taken = f3[0] ? ~z : z;
      seq.push_back(mk(4'd10, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, taken, 1'b0, 1'b0));
    end
    foreach (seq[i]) seq[i].imm = imm_of(o);
  endtask

  // Called one step after a clock edge that leaves the DUT in FETCH.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    obs_t seq[$];
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build(o, f3, f7, z, seq);
    foreach (seq[i]) sb.push_back(seq[i]);
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  task automatic issue_random();
    logic [6:0] o;
    int k;
    k = $urandom_range(0, 6);
    case (k)
      0: o = LW;
      1: o = SW;
      2: o = RT;
      3: o = IT;
      4: o = BR;
      5: o = JL;
      default: begin
        o = 7'($urandom);
        while (o == LW || o == SW || o == RT || o == IT || o == BR || o == JL) o = 7'($urandom);
      end
    endcase
    issue(o, (o == BR) ? 3'($urandom_range(0, 1)) : 3'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Monitor: every falling edge with an outstanding expectation is compared.
  always @(negedge clk) begin
    obs_t got, exp;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      got = '{st: state, imm: immsrc, a: alusrca, b: alusrcb, rs: resultsrc, alu: alucontrol,
              adr: adrsrc, ir: irwrite, pc: pcwrite, rw: regwrite, mw: memwrite};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_outputs t=%0t got {%s} expected {%s}", $time, fmt(got), fmt(exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t seq[$];
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    #3;
    check("reset_state", int'(state), 0);
    check("reset_enables", int'({irwrite, pcwrite, regwrite, memwrite}), 0);
    sb.push_back(rst_rec(7'b0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases from the instruction set's corner behaviour.
    issue(LW, 3'b010, 1'b0, 1'b0);
    issue(SW, 3'b010, 1'b0, 1'b1);
    issue(RT, 3'b000, 1'b1, 1'b0);
    issue(RT, 3'b000, 1'b0, 1'b0);
    issue(RT, 3'b010, 1'b0, 1'b0);
    issue(IT, 3'b000, 1'b1, 1'b0);
    issue(BR, 3'b000, 1'b0, 1'b1);
    issue(BR, 3'b000, 1'b0, 1'b0);
    issue(BR, 3'b001, 1'b0, 1'b0);
    issue(BR, 3'b001, 1'b0, 1'b1);
    issue(JL, 3'b000, 1'b0, 1'b0);
    issue(7'b0000000, 3'b000, 1'b0, 1'b0);

    repeat (200) issue_random();

    // Reset asserted asynchronously while a store sits in its write cycle.
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    build(SW, 3'b010, 1'b0, 1'b0, seq);
    foreach (seq[i]) sb.push_back(seq[i]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_state", int'(state), 0);
    check("async_reset_memwrite", int'(memwrite), 0);
    check("async_reset_enables", int'({irwrite, pcwrite, regwrite, memwrite}), 0);
    check("async_reset_alusrcb", int'(alusrcb), 2);
    sb.push_back(rst_rec(SW));
    @(posedge clk); #1;
    check("held_reset_state", int'(state), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(LW, 3'b010, 1'b0, 1'b0);
    repeat (20) issue_random();

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
